// File: rtl/smpl_loader.sv
// smpl_loader: serial program loader for the SMPL SoC.
// Takes a byte stream framed as LEN_HI LEN_LO {HI LO}*N CSUM. It packs the
// data bytes into 16-bit words and writes them into instruction memory from
// address 0 upward. The core is held in reset until the whole image has been
// written and the XOR checksum matches.
//
// Ports:
//   clock, reset          rising-edge clock; reset is async, active-high
//   rx_valid, rx_data     incoming byte stream
//   rx_ready              byte is accepted when rx_valid && rx_ready
//   imem_wen/addr/wdata   registered one-cycle instruction memory write
//   core_reset            held high until a verified image is loaded
//   done                  image loaded and verified (core running)
//   error                 bad length or checksum; sticky until reset
module smpl_loader #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_RUN, S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       n_words;
    logic [7:0]        hi_byte;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] cnt;

    logic              accept;
    logic [15:0]       len_word;
    logic              last_word;

    // rx_ready is a pure state decode, so there is no path from rx_valid.
    assign rx_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                        (state == S_DATA_HI) || (state == S_DATA_LO) ||
                        (state == S_CSUM);
    assign accept     = rx_valid && rx_ready;
    assign len_word   = {len_hi, rx_data};
    // The word being accepted in DATA_LO is the last one when cnt == N-1.
    assign last_word  = ((16'(cnt) + 16'd1) == n_words);

    assign done       = (state == S_RUN);
    assign core_reset = (state != S_RUN);
    assign error      = (state == S_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = S_LEN_HI;
            S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_word > 16'(DEPTH))  state_nxt = S_ERROR;
                    else if (len_word == 16'd0) state_nxt = S_CSUM;
                    else                        state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
            S_DATA_LO: if (accept) state_nxt = last_word ? S_CSUM : S_DATA_HI;
            S_CSUM:    if (accept) state_nxt = (rx_data == csum) ? S_RUN : S_ERROR;
            default:   state_nxt = state;   // RUN and ERROR only leave on reset
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_hi     <= '0;
            n_words    <= '0;
            hi_byte    <= '0;
            csum       <= '0;
            cnt        <= '0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_wen <= 1'b0;
            if (accept) begin
                // The checksum byte itself is not folded into the running XOR.
                if (state != S_CSUM) csum <= csum ^ rx_data;
                case (state)
                    S_LEN_HI:  len_hi  <= rx_data;
                    S_LEN_LO:  n_words <= len_word;
                    S_DATA_HI: hi_byte <= rx_data;
                    S_DATA_LO: begin
                        imem_wen   <= 1'b1;
                        imem_addr  <= cnt;
                        imem_wdata <= {hi_byte, rx_data};
                        cnt        <= cnt + CNT_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/smpl_loader.md
# smpl_loader

Serial program loader for the SMPL SoC that fills instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into the instruction ROM array. It holds the core in reset until a complete, checksum-verified image has been written. It sits directly upstream of the SoC instruction memory and the `smpl_core` reset input.

## Interface
- `ADDR_W`, 13: instruction address width; matches the core `iaddr` width.
- `DEPTH`, 128: instruction memory depth in words; this is the maximum legal image length.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  incoming byte.
- `rx_ready`  out  1  loader can accept a byte; a byte transfers on a cycle where `rx_valid && rx_ready`.
- `imem_wen`  out  1  instruction memory write strobe; one-cycle pulse per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  16  instruction word to write.
- `core_reset`  out  1  reset to `smpl_core`; high until the load succeeds.
- `done`  out  1  image loaded and verified; the core is running.
- `error`  out  1  load failed; sticky until `reset`.

## Operation
- Frame format, in byte order:
  - `LEN_HI`, `LEN_LO`: word count N, big-endian.
  - N words, each sent as high byte then low byte.
  - `CSUM`: XOR of every preceding byte in the frame, including both length bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RUN, ERROR.
- Transitions:
  - IDLE -> LEN_HI unconditionally on the first clock after reset.
  - LEN_HI -> LEN_LO on accept.
  - LEN_LO on accept:
    - if N > DEPTH -> ERROR;
    - else if N == 0 -> CSUM;
    - else -> DATA_HI.
  - DATA_HI -> DATA_LO on accept; the byte is latched as the word's upper half.
  - DATA_LO on accept:
    - the word is written;
    - -> CSUM if it was word N-1, else -> DATA_HI.
  - CSUM on accept:
    - byte == running XOR -> RUN;
    - else -> ERROR.
  - RUN and ERROR are terminal; only `reset` leaves them.
- `rx_ready` = 1 exactly in states LEN_HI through CSUM. It is a decode of the state register and has no combinational path from `rx_valid`.
- The running XOR is an 8-bit register. It clears on reset and updates on every accepted byte except the CSUM byte.
- Word counter:
  - `ADDR_W` bits wide; clears on reset;
  - increments after each write;
  - `imem_addr` = counter value at write time, so the first word goes to address 0.
- N is compared as a 16-bit unsigned value against DEPTH. N == DEPTH is legal.
- Bytes offered while `rx_ready` = 0 are not consumed. The loader does not detect or flag them.

## Timing
- Reset values: `rx_ready`=0, `imem_wen`=0, `imem_addr`=0, `imem_wdata`=0, `core_reset`=1, `done`=0, `error`=0. State is IDLE; the counter and XOR are 0.
- `rx_ready` rises on the first rising clock edge after `reset` deasserts.
- Write latency:
  - `imem_wen`, `imem_addr` and `imem_wdata` are registered;
  - the strobe is high for exactly one cycle, the cycle after the DATA_LO byte is accepted;
  - address and data hold their values until the next write.
- Success:
  - `core_reset` falls and `done` rises on the same edge, one cycle after the matching CSUM byte is accepted;
  - both hold until `reset`.
- Failure:
  - `error` rises one cycle after the failing byte (LEN_LO with N > DEPTH, or a mismatched CSUM);
  - `core_reset` stays 1 and no further writes occur.
- Back-to-back bytes:
  - one byte per cycle is sustained;
  - a word completes every 2 accepted bytes, with no bubbles inserted by the loader.
- `rx_valid` gaps of any length leave state, counter and XOR unchanged.
- Reset mid-load:
  - all outputs return to their reset values immediately (asynchronously);
  - `core_reset` reasserts;
  - the next frame starts at address 0;
  - memory contents already written are not cleared.

## Test plan
- Bytes 00 02 12 34 AB CD 42, one per cycle -> writes addr0=0x1234 and addr1=0xABCD, one-cycle strobes 2 cycles apart; `done`=1 and `core_reset`=0 one cycle after byte 0x42; `rx_ready`=0 thereafter.
- Same frame with checksum 0x43 -> both writes occur; `error`=1 one cycle after the CSUM byte; `core_reset` stays 1 and `done` stays 0.
- Bytes 00 00 00 -> no `imem_wen` pulse; `done`=1 one cycle after the third byte.
- Bytes 00 81 -> `error`=1 one cycle after the second byte; no writes; `rx_ready`=0.
- First frame with 0-3 random idle cycles of `rx_valid` between bytes -> same writes, addresses and final `done` as the back-to-back case.
- Assert `reset` after 4 bytes of the first frame, then resend the full frame -> all outputs show reset values during reset; writes restart at addr0; `done`=1 at the end.
